// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Moore-style main controller for a shared multi-cycle RV32I datapath. The
// datapath has one ALU, one unified instruction/data memory and the
// IR/OldPC/A/WriteData/ALUOut/Data registers. Each instruction is stepped
// through fetch, decode, execute, memory and writeback states. Memory states
// stall on mem_ready, and give up after WAIT_LIMIT waiting cycles.
//
// Supported: lw, sw, add/sub/and/or/xor/slt/sll/srl,
//            addi/andi/ori/xori/slti/slli/srli, beq, bne, jal.
//
// Ports
//   clk           clock
//   rst           synchronous active-high reset
//   op            instruction[6:0] from IR
//   funct3        instruction[14:12]
//   funct7        instruction[30]
//   Zero          ALU zero flag
//   mem_ready     memory access completes this cycle
//   PCWrite       PC register enable
//   AdrSrc        memory address select: 0 PC, 1 ALUOut
//   MemWrite      memory write strobe
//   IRWrite       IR/OldPC enable
//   ResultSrc     00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA       00 PC, 01 OldPC, 10 A
//   ALUSrcB       00 WriteData, 01 ImmExt, 10 constant 4
//   ALUctrl       000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt,
//                 110 sll, 111 srl
//   ImmSrc        000 I, 001 S, 010 B, 100 J
//   RegWrite      register file write enable
//   illegal_instr one-cycle pulse on an undecodable instruction
//   mem_timeout   one-cycle pulse when a memory wait times out
//   state_dbg     current state encoding
// -----------------------------------------------------------------------------
module multicycle_controller #(
   parameter int STATE_WIDTH = 4,
   parameter int WAIT_LIMIT  = 16   // 0 disables the timeout
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [6:0]             op,
   input  logic [2:0]             funct3,
   input  logic                   funct7,
   input  logic                   Zero,
   input  logic                   mem_ready,
   output logic                   PCWrite,
   output logic                   AdrSrc,
   output logic                   MemWrite,
   output logic                   IRWrite,
   output logic [1:0]             ResultSrc,
   output logic [1:0]             ALUSrcA,
   output logic [1:0]             ALUSrcB,
   output logic [2:0]             ALUctrl,
   output logic [2:0]             ImmSrc,
   output logic                   RegWrite,
   output logic                   illegal_instr,
   output logic                   mem_timeout,
   output logic [STATE_WIDTH-1:0] state_dbg
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

   // The counter only needs to reach WAIT_LIMIT-1.
   localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

   state_t           state, next_state;
   logic [CNT_W-1:0] wait_cnt;
   logic             waiting;
   logic             timeout;

   // R-type and I-type arithmetic share one legality rule. funct3 011 (sltu)
   // is not supported. Shifts with bit 30 set would be sra/srai, which are
   // also unsupported. For the other funct3 values, bit 30 is either ignored
   // (R-type) or just an immediate bit (I-type).
   function automatic logic arith_legal(input logic [2:0] f3, input logic f7);
      return !((f3 == 3'b011) || (f7 && ((f3 == 3'b001) || (f3 == 3'b101))));
   endfunction

   // sub only exists in R-type; in I-type, 000 with bit 30 set is still addi.
   function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic f7,
                                             input logic is_r);
      logic [2:0] code;
      code = ALU_ADD;
      case (f3)
         3'b000:  code = (is_r && f7) ? ALU_SUB : ALU_ADD;
         3'b111:  code = ALU_AND;
         3'b110:  code = ALU_OR;
         3'b100:  code = ALU_XOR;
         3'b010:  code = ALU_SLT;
         3'b001:  code = ALU_SLL;
         3'b101:  code = ALU_SRL;
         default: code = ALU_ADD;
      endcase
      return code;
   endfunction

   assign waiting = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
   assign timeout = (WAIT_LIMIT != 0) && waiting && !mem_ready &&
                    (wait_cnt == CNT_W'(WAIT_LIMIT - 1));

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; the combinational block below uses blocking (=).
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FETCH;
         wait_cnt <= '0;
      end else begin
         state <= next_state;
         // A timeout from FETCH re-enters FETCH, so clear on it explicitly.
         if ((next_state != state) || timeout)
            wait_cnt <= '0;
         else if (waiting && !mem_ready)
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // NOTE: every output gets a default before the case statement, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      next_state    = state;
      PCWrite       = 1'b0;
      AdrSrc        = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      ResultSrc     = 2'b00;
      ALUSrcA       = 2'b00;
      ALUSrcB       = 2'b00;
      ALUctrl       = ALU_ADD;
      RegWrite      = 1'b0;
      illegal_instr = 1'b0;
      mem_timeout   = 1'b0;

      case (state)
         FETCH: begin
            // The ALU computes PC+4 while memory returns the instruction.
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = mem_ready;
            PCWrite   = mem_ready;
            if (mem_ready) next_state = DECODE;
         end
         DECODE: begin
            // OldPC + ImmExt: the branch target is precomputed into ALUOut.
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b01;
            next_state = FETCH;
            case (op)
               OP_LOAD, OP_STORE:
                  if (funct3 == 3'b010) next_state = MEMADR;
                  else                  illegal_instr = 1'b1;
               OP_R:
                  if (arith_legal(funct3, funct7)) next_state = EXECR;
                  else                             illegal_instr = 1'b1;
               OP_I:
                  if (arith_legal(funct3, funct7)) next_state = EXECI;
                  else                             illegal_instr = 1'b1;
               OP_BRANCH:
                  if (funct3 == 3'b000 || funct3 == 3'b001) next_state = BRANCH;
                  else                                      illegal_instr = 1'b1;
               OP_JAL:
                  next_state = JAL;
               default:
                  illegal_instr = 1'b1;
            endcase
         end
         MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            if (op == OP_STORE)     next_state = MEMWRITE;
            else if (op == OP_LOAD) next_state = MEMREAD;
            else                    next_state = FETCH;
         end
         MEMREAD: begin
            AdrSrc = 1'b1;
            if (mem_ready) next_state = MEMWB;
         end
         MEMWB: begin
            ResultSrc  = 2'b01;
            RegWrite   = 1'b1;
            next_state = FETCH;
         end
         MEMWRITE: begin
            // The strobe is held for the whole wait, not pulsed.
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            if (mem_ready) next_state = FETCH;
         end
         EXECR: begin
            ALUSrcA    = 2'b10;
            ALUctrl    = alu_decode(funct3, funct7, 1'b1);
            next_state = ALUWB;
         end
         EXECI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUctrl    = alu_decode(funct3, funct7, 1'b0);
            next_state = ALUWB;
         end
         ALUWB: begin
            RegWrite   = 1'b1;
            next_state = FETCH;
         end
         BRANCH: begin
            // Compare rs1 - rs2. On a taken branch, PC loads the target from ALUOut.
            ALUSrcA    = 2'b10;
            ALUctrl    = ALU_SUB;
            PCWrite    = ((funct3 == 3'b000) && Zero) || ((funct3 == 3'b001) && !Zero);
            next_state = FETCH;
         end
         JAL: begin
            // PC <- target held in ALUOut, while ALU computes OldPC+4 for rd.
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
            PCWrite    = 1'b1;
            next_state = ALUWB;
         end
         default: next_state = FETCH;
      endcase

      if (timeout) begin
         PCWrite     = 1'b0;
         IRWrite     = 1'b0;
         MemWrite    = 1'b0;
         RegWrite    = 1'b0;
         mem_timeout = 1'b1;
         next_state  = FETCH;
      end

      // During reset, nothing may write. The selects show their FETCH values.
      if (rst) begin
         PCWrite       = 1'b0;
         IRWrite       = 1'b0;
         MemWrite      = 1'b0;
         RegWrite      = 1'b0;
         illegal_instr = 1'b0;
         mem_timeout   = 1'b0;
         AdrSrc        = 1'b0;
         ALUSrcA       = 2'b00;
         ALUSrcB       = 2'b10;
         ALUctrl       = ALU_ADD;
         ResultSrc     = 2'b10;
         next_state    = FETCH;
      end
   end

   // The immediate format depends only on the opcode, so it is valid in every state.
   always_comb begin
      ImmSrc = 3'b000;
      case (op)
         OP_LOAD, OP_I: ImmSrc = 3'b000;
         OP_STORE:      ImmSrc = 3'b001;
         OP_BRANCH:     ImmSrc = 3'b010;
         OP_JAL:        ImmSrc = 3'b100;
         default:       ImmSrc = 3'b000;
      endcase
   end

   assign state_dbg = STATE_WIDTH'(state);

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Self-checking bench for multicycle_controller. For each instruction, the
// reference model builds the expected state path from the instruction class.
// It then derives every cycle's expected outputs from the state number and
// the current inputs. The bench runs a directed vector table, hand-written
// reset/stall/timeout sequences and randomized instruction streams.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

   localparam int WAIT_LIMIT = 16;

   localparam logic [6:0] LOAD  = 7'b0000011;
   localparam logic [6:0] STORE = 7'b0100011;
   localparam logic [6:0] OPR   = 7'b0110011;
   localparam logic [6:0] OPI   = 7'b0010011;
   localparam logic [6:0] BR    = 7'b1100011;
   localparam logic [6:0] JALOP = 7'b1101111;

   // ALU code per funct3 (f3=7 down to f3=0): and, or, srl, xor, -, slt, sll, add.
   localparam logic [23:0] ALU_BY_F3 = {3'd2, 3'd3, 3'd7, 3'd4, 3'd0, 3'd5, 3'd6, 3'd0};

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7;
   logic       Zero;
   logic       mem_ready;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0] ALUctrl, ImmSrc;
   logic       illegal_instr, mem_timeout;
   logic [3:0] state_dbg;

   multicycle_controller #(.STATE_WIDTH(4), .WAIT_LIMIT(WAIT_LIMIT)) dut (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
      .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUctrl(ALUctrl), .ImmSrc(ImmSrc),
      .RegWrite(RegWrite), .illegal_instr(illegal_instr),
      .mem_timeout(mem_timeout), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, adr, mw, irw;
      logic [1:0] rs, sa, sb;
      logic [2:0] alu, imm;
      logic       rw, ill, to;
   } outs_t;

   typedef struct {
      int cycles, mw, rw, pcw, ill, to_at;
   } cnt_t;

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7, z;
      int         cycles, rw, pcw, ill;
   } vec_t;

   typedef int path_t[$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit legal(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      case (o)
         LOAD, STORE: return f3 == 3'b010;
         OPR, OPI:    return !(f3 == 3'b011 || (f7 && (f3 == 3'b001 || f3 == 3'b101)));
         BR:          return f3 == 3'b000 || f3 == 3'b001;
         JALOP:       return 1'b1;
         default:     return 1'b0;
      endcase
   endfunction

   // Nominal state walk for one instruction (spec state numbers).
   function automatic path_t path_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      path_t p;
      if (!legal(o, f3, f7)) p = '{0, 1};
      else case (o)
         LOAD:    p = '{0, 1, 2, 3, 4};
         STORE:   p = '{0, 1, 2, 5};
         OPR:     p = '{0, 1, 6, 8};
         OPI:     p = '{0, 1, 7, 8};
         BR:      p = '{0, 1, 9};
         default: p = '{0, 1, 10, 8};
      endcase
      return p;
   endfunction

   function automatic outs_t model_out(input int st, input bit to);
      outs_t      e;
      logic [23:0] tbl;
      tbl = ALU_BY_F3;
      e = '0;
      e.st = 4'(st);
      case (op)
         STORE:   e.imm = 3'b001;
         BR:      e.imm = 3'b010;
         JALOP:   e.imm = 3'b100;
         default: e.imm = 3'b000;
      endcase
      case (st)
         0:  begin e.sb = 2'b10; e.rs = 2'b10; e.pcw = mem_ready; e.irw = mem_ready; end
         1:  begin e.sa = 2'b01; e.sb = 2'b01; e.ill = !legal(op, funct3, funct7); end
         2:  begin e.sa = 2'b10; e.sb = 2'b01; end
         3:  e.adr = 1'b1;
         4:  begin e.rs = 2'b01; e.rw = 1'b1; end
         5:  begin e.adr = 1'b1; e.mw = 1'b1; end
         6:  begin
                e.sa  = 2'b10;
                e.alu = (funct3 == 3'b000 && funct7) ? 3'b001 : tbl[funct3*3 +: 3];
             end
         7:  begin e.sa = 2'b10; e.sb = 2'b01; e.alu = tbl[funct3*3 +: 3]; end
         8:  e.rw = 1'b1;
         9:  begin
                e.sa  = 2'b10;
                e.alu = 3'b001;
                e.pcw = (funct3 == 3'b000 && Zero) || (funct3 == 3'b001 && !Zero);
             end
         10: begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
         default: ;
      endcase
      if (to) begin
         e.pcw = 1'b0; e.irw = 1'b0; e.mw = 1'b0; e.rw = 1'b0; e.to = 1'b1;
      end
      if (rst) begin
         e.pcw = 1'b0; e.irw = 1'b0; e.mw = 1'b0; e.rw = 1'b0; e.ill = 1'b0; e.to = 1'b0;
         e.adr = 1'b0; e.sa = 2'b00; e.sb = 2'b10; e.rs = 2'b10; e.alu = 3'b000;
      end
      return e;
   endfunction

   // Compare one cycle's outputs; called just after a falling edge.
   task automatic check_cycle(input int st, input bit to);
      outs_t got, exp;
      #1;
      exp = model_out(st, to);
      got = {state_dbg, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
             ALUSrcB, ALUctrl, ImmSrc, RegWrite, illegal_instr, mem_timeout};
      check($sformatf("cycle st=%0d op=%b f3=%b f7=%b rst=%b", st, op, funct3, funct7, rst),
            32'(got), 32'(exp));
   endtask

   // Run one instruction from FETCH. fs/ms give the number of mem_ready-low
   // cycles in FETCH and in the memory state.
   task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic z, input int fs, input int ms, output cnt_t c);
      path_t p;
      c = '{default: 0};
      op = o; funct3 = f3; funct7 = f7; Zero = z;
      p = path_of(o, f3, f7);
      foreach (p[i]) begin
         if (p[i] == 0 || p[i] == 3 || p[i] == 5) begin
            for (int k = 0; k < WAIT_LIMIT; k++) begin
               bit to;
               mem_ready = (k >= ((p[i] == 0) ? fs : ms));
               to = !mem_ready && (k == WAIT_LIMIT - 1);
               check_cycle(p[i], to);
               c.cycles++;
               c.mw  += int'(MemWrite);
               c.pcw += int'(PCWrite);
               @(negedge clk);
               if (to) begin
                  c.to_at = k + 1;
                  return;
               end
               if (mem_ready) break;
            end
         end else begin
            mem_ready = 1'($urandom);
            check_cycle(p[i], 1'b0);
            c.cycles++;
            c.rw  += int'(RegWrite);
            c.pcw += int'(PCWrite);
            c.ill += int'(illegal_instr);
            c.mw  += int'(MemWrite);
            @(negedge clk);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vecs[16];
      cnt_t c;
      int   mw_in_rst;

      vecs[0]  = '{LOAD,  3'b010, 1'b0, 1'b0, 5, 1, 1, 0};
      vecs[1]  = '{STORE, 3'b010, 1'b0, 1'b0, 4, 0, 1, 0};
      vecs[2]  = '{OPR,   3'b000, 1'b0, 1'b0, 4, 1, 1, 0};
      vecs[3]  = '{OPR,   3'b000, 1'b1, 1'b0, 4, 1, 1, 0};
      vecs[4]  = '{OPR,   3'b100, 1'b0, 1'b0, 4, 1, 1, 0};
      vecs[5]  = '{OPI,   3'b000, 1'b1, 1'b0, 4, 1, 1, 0};
      vecs[6]  = '{OPI,   3'b001, 1'b0, 1'b0, 4, 1, 1, 0};
      vecs[7]  = '{OPI,   3'b001, 1'b1, 1'b0, 2, 0, 1, 1};
      vecs[8]  = '{OPR,   3'b011, 1'b0, 1'b0, 2, 0, 1, 1};
      vecs[9]  = '{BR,    3'b000, 1'b0, 1'b1, 3, 0, 2, 0};
      vecs[10] = '{BR,    3'b000, 1'b0, 1'b0, 3, 0, 1, 0};
      vecs[11] = '{BR,    3'b001, 1'b0, 1'b0, 3, 0, 2, 0};
      vecs[12] = '{BR,    3'b001, 1'b0, 1'b1, 3, 0, 1, 0};
      vecs[13] = '{BR,    3'b100, 1'b0, 1'b0, 2, 0, 1, 1};
      vecs[14] = '{JALOP, 3'b000, 1'b0, 1'b0, 4, 1, 2, 0};
      vecs[15] = '{7'h7F, 3'b000, 1'b0, 1'b0, 2, 0, 1, 1};

      // Reset state: outputs are forced quiet even though mem_ready is high.
      rst = 1'b1; mem_ready = 1'b1; op = 7'h7F; funct3 = '0; funct7 = 1'b0; Zero = 1'b0;
      @(negedge clk);
      check_cycle(0, 1'b0);
      @(negedge clk);
      check_cycle(0, 1'b0);
      rst = 1'b0;

      // Directed table: mem_ready held high in the waiting states.
      foreach (vecs[i]) begin
         run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, 0, 0, c);
         check($sformatf("vec%0d cycles", i), c.cycles, vecs[i].cycles);
         check($sformatf("vec%0d regwrites", i), c.rw, vecs[i].rw);
         check($sformatf("vec%0d pcwrites", i), c.pcw, vecs[i].pcw);
         check($sformatf("vec%0d illegal", i), c.ill, vecs[i].ill);
      end

      // Reset in the middle of a stalled MEMWRITE abandons the store.
      op = STORE; funct3 = 3'b010; funct7 = 1'b0; mem_ready = 1'b1;
      check_cycle(0, 1'b0); @(negedge clk);
      check_cycle(1, 1'b0); @(negedge clk);
      check_cycle(2, 1'b0); @(negedge clk);
      mem_ready = 1'b0;
      check_cycle(5, 1'b0); @(negedge clk);
      check_cycle(5, 1'b0); @(negedge clk);
      rst = 1'b1; mw_in_rst = 0;
      check_cycle(5, 1'b0); mw_in_rst += int'(MemWrite); @(negedge clk);
      check_cycle(0, 1'b0); mw_in_rst += int'(MemWrite); @(negedge clk);
      rst = 1'b0; op = 7'h7F; mem_ready = 1'b1;
      check_cycle(0, 1'b0);
      check("rst_state_after", 32'(state_dbg), 32'd0);
      check("rst_memwrite_during", mw_in_rst, 0);
      @(negedge clk);
      check_cycle(1, 1'b0); @(negedge clk);

      // sw with 5 stall cycles: strobe held 6 cycles.
      run_instr(STORE, 3'b010, 1'b0, 1'b0, 0, 5, c);
      check("sw_stall5_memwrite_cycles", c.mw, 6);
      check("sw_stall5_cycles", c.cycles, 9);
      check("sw_stall5_no_timeout", c.to_at, 0);

      // mem_ready on the limit cycle wins over the timeout.
      run_instr(STORE, 3'b010, 1'b0, 1'b0, 0, WAIT_LIMIT - 1, c);
      check("sw_ready_at_limit_timeout", c.to_at, 0);
      check("sw_ready_at_limit_memwrite", c.mw, WAIT_LIMIT);

      // sw with mem_ready never rising: timeout on the 16th waiting cycle.
      run_instr(STORE, 3'b010, 1'b0, 1'b0, 0, 1000, c);
      check("sw_timeout_at", c.to_at, WAIT_LIMIT);
      check("sw_timeout_memwrite", c.mw, WAIT_LIMIT - 1);
      #1 check("sw_timeout_next_state", 32'(state_dbg), 32'd0);

      // Timeout during FETCH re-enters FETCH with a fresh counter.
      run_instr(LOAD, 3'b010, 1'b0, 1'b0, 1000, 0, c);
      check("fetch_timeout_at", c.to_at, WAIT_LIMIT);
      run_instr(LOAD, 3'b010, 1'b0, 1'b0, 3, 2, c);
      check("lw_after_fetch_timeout_cycles", c.cycles, 10);

      // Randomized instruction stream with random stalls and timeouts.
      for (int i = 0; i < 300; i++) begin
         logic [6:0] o;
         logic [2:0] f3;
         int         fs, ms;
         case ($urandom_range(0, 6))
            0:       o = LOAD;
            1:       o = STORE;
            2:       o = OPR;
            3:       o = OPI;
            4:       o = BR;
            5:       o = JALOP;
            default: o = 7'($urandom);
         endcase
         f3 = (o == LOAD || o == STORE) ? 3'b010 : 3'($urandom);
         fs = ($urandom_range(0, 19) == 0) ? 100 : $urandom_range(0, 3);
         ms = ($urandom_range(0, 9) == 0) ? 100 : $urandom_range(0, 4);
         run_instr(o, f3, 1'($urandom), 1'($urandom), fs, ms, c);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style main controller that sequences the shared multi-cycle RV32I datapath: one ALU, one unified instruction/data memory, and the IR/OldPC/A/WriteData/ALUOut/Data registers.
- Decodes op/funct3/funct7 in DECODE, then walks each instruction through fetch, execute, memory and writeback states, issuing enables and mux selects each cycle.
- Stalls on a ready handshake from memory and aborts on a wait timeout.
- Supported instructions: lw, sw, add/sub/and/or/xor/slt/sll/srl, addi/andi/ori/xori/slti/slli/srli, beq, bne, jal.

Parameters:
- STATE_WIDTH, 4, width of state_dbg.
- WAIT_LIMIT, 16, maximum cycles spent waiting for mem_ready in one memory state. 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- op  in  7  instruction[6:0] from IR
- funct3  in  3  instruction[14:12]
- funct7  in  1  instruction[30]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 PC, 1 ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR/OldPC enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A
- ALUSrcB  out  2  00 WriteData, 01 ImmExt, 10 constant 4
- ALUctrl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
- ImmSrc  out  3  000 I, 001 S, 010 B, 100 J
- RegWrite  out  1  register file write enable
- illegal_instr  out  1  one-cycle pulse on an undecodable instruction
- mem_timeout  out  1  one-cycle pulse on a wait timeout
- state_dbg  out  STATE_WIDTH  current state

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high: rst sampled high at a clk edge sets state to FETCH and clears the wait counter and pulses.
- While rst is high, all enables (PCWrite, IRWrite, MemWrite, RegWrite) and both pulse outputs are forced to 0, regardless of state. Selects then take their FETCH values.
- Reset mid-operation (e.g., mid-MEMWRITE wait) abandons the instruction; no further write is issued.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10.
- ImmSrc is decoded from op in every state: 0000011/0010011 give I, 0100011 gives S, 1100011 gives B, 1101111 gives J, anything else gives 000.
- Unlisted outputs are 0 in every state; ALUctrl defaults to add.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Stay in FETCH until mem_ready, then go to DECODE.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, add (precomputes the branch target into ALUOut).
  - Next state by op: lw/sw go to MEMADR; 0110011 goes to EXECR; 0010011 goes to EXECI; 1100011 goes to BRANCH; 1101111 goes to JAL.
  - Any other op, an undefined funct3/funct7 combination, or a branch funct3 other than 000/001: illegal_instr=1 for this cycle, go to FETCH, no writes.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. op 0000011 goes to MEMREAD; 0100011 goes to MEMWRITE.
- MEMREAD: AdrSrc=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 held continuously until mem_ready, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, then ALUWB. ALUctrl decode by funct3/funct7:
  - 000/0 add, 000/1 sub, 111 and, 110 or, 100 xor, 010 slt, 001/0 sll, 101/0 srl.
- EXECI: ALUSrcA=10, ALUSrcB=01, then ALUWB. Same funct3 mapping as EXECR, except:
  - 000 is always add.
  - 001 and 101 require funct7=0.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite = (funct3==000 & Zero) | (funct3==001 & ~Zero).
  - Then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then ALUWB (writes OldPC+4 into rd).
- Nominal latency with mem_ready always 1: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; branch 3 cycles.
- Wait timeout:
  - The wait counter increments each cycle spent in FETCH/MEMREAD/MEMWRITE with mem_ready=0, and clears on any state change.
  - If WAIT_LIMIT≠0 and the counter reaches WAIT_LIMIT-1 with mem_ready=0: mem_timeout=1 that cycle, all enables are 0 that cycle, and the next state is FETCH. From FETCH this means re-entering FETCH with the counter cleared.
  - mem_ready arriving in the same cycle as the limit takes priority: normal transition, no timeout.

Test Plan:
- rst=1 for 2 cycles from state MEMWRITE with mem_ready=0 -> MemWrite=0 during rst, state_dbg=0 afterwards, no write observed.
- lw (op 0000011, funct3 010), mem_ready=1 every cycle -> states 0,1,2,3,4,0; RegWrite=1 only in MEMWB with ResultSrc=01; 5 cycles.
- sub (op 0110011, funct3 000, funct7 1) -> EXECR drives ALUctrl=001, ALUSrcB=00; ALUWB RegWrite=1; 4 cycles.
- bne with Zero=0 -> PCWrite=1 in BRANCH; beq with Zero=0 -> PCWrite=0; both return to FETCH after 3 cycles.
- sw with mem_ready low 5 cycles, WAIT_LIMIT=16 -> MemWrite held high 6 cycles, then FETCH. The same stimulus with mem_ready never rising -> mem_timeout pulse on the 16th waiting cycle, then FETCH.
- op 1111111 -> illegal_instr=1 for one cycle in DECODE, no PCWrite/RegWrite/MemWrite, back to FETCH.
